// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - register file access bus (write port plus two read ports)
//
// Signals:
//   reg_write        write enable, sampled on rising clk
//   reg_write_dest   destination register address
//   reg_write_data   data to write
//   reg_read_addr_1  read port 1 address
//   reg_read_addr_2  read port 2 address
//   reg_read_data_1  read port 1 data (combinational)
//   reg_read_data_2  read port 2 data (combinational)
// Modports:
//   master  decode/writeback side, drives addresses and write data
//   slave   register file side, drives read data
interface reg_file_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic [ADDR_W-1:0] reg_read_addr_1;
    logic [ADDR_W-1:0] reg_read_addr_2;
    logic [DATA_W-1:0] reg_read_data_1;
    logic [DATA_W-1:0] reg_read_data_2;

    modport master (
        output reg_write,
        output reg_write_dest,
        output reg_write_data,
        output reg_read_addr_1,
        output reg_read_addr_2,
        input  reg_read_data_1,
        input  reg_read_data_2
    );

    modport slave (
        input  reg_write,
        input  reg_write_dest,
        input  reg_write_data,
        input  reg_read_addr_1,
        input  reg_read_addr_2,
        output reg_read_data_1,
        output reg_read_data_2
    );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32 x 64-bit register file, one synchronous write, two combinational reads
//
// Ports:
//   clk    system clock; writes take effect on the rising edge
//   reset  asynchronous active-high; clears every register immediately
//   bus    reg_file_if slave modport carrying the write port and both read ports
// Register 0 is hardwired to zero: writes to it are dropped and reads return 0.
// There is no write-to-read bypass; a read of the register being written shows
// the old value until the clock edge.
module reg_file #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic    clk,
    input  logic    reset,
    reg_file_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Entry 0 is reset like the others and never written, so it stays zero;
    // the read mux also forces zero so address 0 is correct by construction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.reg_write && (bus.reg_write_dest != '0)) begin
            regs[bus.reg_write_dest] <= bus.reg_write_data;
        end
    end

    assign bus.reg_read_data_1 = (bus.reg_read_addr_1 == '0) ? '0 : regs[bus.reg_read_addr_1];
    assign bus.reg_read_data_2 = (bus.reg_read_addr_2 == '0) ? '0 : regs[bus.reg_read_addr_2];
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.reg_write      = 1'b1;
        bus.reg_write_dest = a;
        bus.reg_write_data = d;
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
    endtask

    task automatic test_reset;
        bus.reg_write       = 1'b0;
        bus.reg_write_dest  = '0;
        bus.reg_write_data  = '0;
        bus.reg_read_addr_1 = '0;
        bus.reg_read_addr_2 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.reg_read_addr_1 = ADDR_W'(a);
            bus.reg_read_addr_2 = ADDR_W'(31 - a);
            #1;
            n_checks++;
            if (bus.reg_read_data_1 !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_rd1 addr=%0d got=%h exp=0", a, bus.reg_read_data_1);
            end
            n_checks++;
            if (bus.reg_read_data_2 !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_rd2 addr=%0d got=%h exp=0", 31 - a, bus.reg_read_data_2);
            end
        end
    endtask

    task automatic test_basic_write;
        @(negedge clk);
        bus.reg_write       = 1'b1;
        bus.reg_write_dest  = 5'd7;
        bus.reg_write_data  = 64'd916;
        bus.reg_read_addr_1 = 5'd6;
        bus.reg_read_addr_2 = 5'd5;
        #1;
        n_checks++;
        if (bus.reg_read_data_1 !== 64'd0 || bus.reg_read_data_2 !== 64'd0) begin
            n_fail++;
            $display("FAIL basic_pre got=%h/%h exp=0/0", bus.reg_read_data_1, bus.reg_read_data_2);
        end
        @(posedge clk);
        #1;
        bus.reg_write       = 1'b0;
        bus.reg_read_addr_1 = 5'd7;
        #1;
        n_checks++;
        if (bus.reg_read_data_1 !== 64'd916) begin
            n_fail++;
            $display("FAIL basic_rd1 got=%0d exp=916", bus.reg_read_data_1);
        end
        n_checks++;
        if (bus.reg_read_data_2 !== 64'd0) begin
            n_fail++;
            $display("FAIL basic_rd2 got=%0d exp=0", bus.reg_read_data_2);
        end
    endtask

    task automatic test_full_width;
        write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        write_reg(5'd30, 64'h8000_0000_0000_0001);
        bus.reg_read_addr_1 = 5'd31;
        bus.reg_read_addr_2 = 5'd31;
        #1;
        n_checks++;
        if (bus.reg_read_data_1 !== 64'hFFFF_FFFF_FFFF_FFFF || bus.reg_read_data_2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL full_width got=%h/%h exp=ffffffffffffffff", bus.reg_read_data_1, bus.reg_read_data_2);
        end
        // independent ports on different registers, address change is combinational
        bus.reg_read_addr_2 = 5'd30;
        #1;
        n_checks++;
        if (bus.reg_read_data_2 !== 64'h8000_0000_0000_0001 || bus.reg_read_data_1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL indep_ports got=%h/%h exp=ffffffffffffffff/8000000000000001",
                     bus.reg_read_data_1, bus.reg_read_data_2);
        end
    endtask

    task automatic test_reg0_and_disable;
        write_reg(5'd0, 64'd123);
        bus.reg_read_addr_1 = 5'd0;
        bus.reg_read_addr_2 = 5'd0;
        #1;
        n_checks++;
        if (bus.reg_read_data_1 !== 64'd0 || bus.reg_read_data_2 !== 64'd0) begin
            n_fail++;
            $display("FAIL reg0 got=%0d/%0d exp=0/0", bus.reg_read_data_1, bus.reg_read_data_2);
        end
        write_reg(5'd3, 64'h33);
        @(negedge clk);
        bus.reg_write      = 1'b0;
        bus.reg_write_dest = 5'd3;
        bus.reg_write_data = 64'd55;
        @(posedge clk);
        #1;
        bus.reg_read_addr_1 = 5'd3;
        #1;
        n_checks++;
        if (bus.reg_read_data_1 !== 64'h33) begin
            n_fail++;
            $display("FAIL write_disabled got=%h exp=33", bus.reg_read_data_1);
        end
    endtask

    task automatic test_read_during_write;
        write_reg(5'd9, 64'd10);
        @(negedge clk);
        bus.reg_write       = 1'b1;
        bus.reg_write_dest  = 5'd9;
        bus.reg_write_data  = 64'd20;
        bus.reg_read_addr_1 = 5'd9;
        bus.reg_read_addr_2 = 5'd9;
        #1;
        n_checks++;
        if (bus.reg_read_data_1 !== 64'd10 || bus.reg_read_data_2 !== 64'd10) begin
            n_fail++;
            $display("FAIL rdw_before got=%0d/%0d exp=10/10", bus.reg_read_data_1, bus.reg_read_data_2);
        end
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
        n_checks++;
        if (bus.reg_read_data_1 !== 64'd20 || bus.reg_read_data_2 !== 64'd20) begin
            n_fail++;
            $display("FAIL rdw_after got=%0d/%0d exp=20/20", bus.reg_read_data_1, bus.reg_read_data_2);
        end
    endtask

    task automatic test_async_reset;
        write_reg(5'd1, 64'h1111);
        write_reg(5'd2, 64'h2222);
        write_reg(5'd3, 64'h3333);
        write_reg(5'd4, 64'h4444);
        @(negedge clk);
        #2;
        bus.reg_read_addr_1 = 5'd1;
        bus.reg_read_addr_2 = 5'd4;
        #1;
        n_checks++;
        if (bus.reg_read_data_1 !== 64'h1111 || bus.reg_read_data_2 !== 64'h4444) begin
            n_fail++;
            $display("FAIL preload got=%h/%h exp=1111/4444", bus.reg_read_data_1, bus.reg_read_data_2);
        end
        // mid-cycle: no clock edge between here and the check
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.reg_read_data_1 !== 64'd0 || bus.reg_read_data_2 !== 64'd0) begin
            n_fail++;
            $display("FAIL async_clear got=%h/%h exp=0/0", bus.reg_read_data_1, bus.reg_read_data_2);
        end
        bus.reg_write      = 1'b1;
        bus.reg_write_dest = 5'd2;
        bus.reg_write_data = 64'd77;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.reg_write = 1'b0;
        reset = 1'b0;
        for (int a = 1; a <= 4; a++) begin
            bus.reg_read_addr_1 = ADDR_W'(a);
            #1;
            n_checks++;
            if (bus.reg_read_data_1 !== 64'd0) begin
                n_fail++;
                $display("FAIL post_reset addr=%0d got=%h exp=0", a, bus.reg_read_data_1);
            end
        end
        bus.reg_read_addr_2 = 5'd31;
        #1;
        n_checks++;
        if (bus.reg_read_data_2 !== 64'd0) begin
            n_fail++;
            $display("FAIL post_reset31 got=%h exp=0", bus.reg_read_data_2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_full_width();
        test_reg0_and_disable();
        test_read_during_write();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
